// File: rtl/layer_ctrl_16_8_pkg.sv
// Shared types and default sizing for the fully-connected layer sequencer.
package layer_ctrl_16_8_pkg;

  localparam int DEF_M      = 16;
  localparam int DEF_N      = 8;
  localparam int DEF_RD_LAT = 1;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } layer_state_t;

  // One stage of the MAC strobe pipeline: read issued, and it is the row's first.
  typedef struct packed {
    logic vld;
    logic first;
  } strobe_t;

endpackage

// File: rtl/layer_ctrl_16_8_if.sv
// Load / memory-address / MAC-strobe / result handshake bundle of the layer sequencer.
interface layer_ctrl_16_8_if #(
  parameter int M = 16,
  parameter int N = 8
);
  logic                     s_valid;
  logic                     s_ready;
  logic                     x_wr_en;
  logic [$clog2(M)-1:0]     x_addr;
  logic [$clog2(M*N)-1:0]   w_addr;
  logic                     mac_clr;
  logic                     mac_en;
  logic                     m_valid;
  logic                     m_ready;
  logic [$clog2(N)-1:0]     y_row;
  logic                     busy;

  modport master (
    input  s_valid, m_ready,
    output s_ready, x_wr_en, x_addr, w_addr, mac_clr, mac_en, m_valid, y_row, busy
  );

  modport slave (
    output s_valid, m_ready,
    input  s_ready, x_wr_en, x_addr, w_addr, mac_clr, mac_en, m_valid, y_row, busy
  );
endinterface

// File: rtl/layer_ctrl_16_8_strobe_delay.sv
// Delays the {valid, first} issue strobe by DEPTH cycles to line up with memory read data.
module layer_ctrl_16_8_strobe_delay
  import layer_ctrl_16_8_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clk,
  input  logic    reset,
  input  strobe_t in_s,
  output strobe_t out_s
);

  strobe_t [DEPTH-1:0] pipe_q, pipe_d;

  // Shift one stage per cycle; stage 0 takes the live issue strobe.
  always_comb begin
    pipe_d    = pipe_q;
    pipe_d[0] = in_s;
    for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
  end

  // Reset drops every in-flight strobe so no MAC update survives an abort.
  always_ff @(posedge clk) begin
    if (reset) pipe_q <= '0;
    else       pipe_q <= pipe_d;
  end

  assign out_s = pipe_q[DEPTH-1];

endmodule

// File: rtl/layer_ctrl_16_8.sv
// Sequencer for an M-input, N-output fixed-point FC layer: loads the input vector,
// walks x-memory / weight-ROM per row, drives MAC strobes, hands results downstream.
module layer_ctrl_16_8
  import layer_ctrl_16_8_pkg::*;
#(
  parameter int M      = DEF_M,
  parameter int N      = DEF_N,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic              clk,
  input  logic              reset,
  layer_ctrl_16_8_if.master bus
);

  localparam int KW = $clog2(M);
  localparam int RW = $clog2(N);
  localparam int WW = $clog2(M*N);
  localparam int DW = $clog2(RD_LAT+1);

  localparam logic [1:0] S_LOAD  = 2'(LOAD);
  localparam logic [1:0] S_ISSUE = 2'(ISSUE);
  localparam logic [1:0] S_DRAIN = 2'(DRAIN);
  localparam logic [1:0] S_OUT   = 2'(OUT);

  localparam logic [KW-1:0] K_LAST = KW'(M-1);
  localparam logic [RW-1:0] R_LAST = RW'(N-1);
  localparam logic [DW-1:0] D_LAST = DW'(RD_LAT-1);

  logic [1:0]    state_q,  state_d;
  logic [KW-1:0] ld_cnt_q, ld_cnt_d;
  logic [KW-1:0] k_q,      k_d;
  logic [RW-1:0] row_q,    row_d;
  logic [DW-1:0] dcnt_q,   dcnt_d;
  logic [KW-1:0] x_addr_q, x_addr_d;
  logic [WW-1:0] w_addr_q, w_addr_d;

  logic          in_load, in_issue, wr, out_hs;
  logic [KW-1:0] x_addr_o;
  logic [WW-1:0] w_addr_o;
  strobe_t       stb_in, stb_out;

  // Handshake and address outputs; addresses hold their last value when idle.
  always_comb begin
    in_load  = (state_q == S_LOAD);
    in_issue = (state_q == S_ISSUE);
    wr       = bus.s_valid & in_load;
    out_hs   = (state_q == S_OUT) & bus.m_ready;
    x_addr_o = x_addr_q;
    w_addr_o = w_addr_q;
    if (in_load)  x_addr_o = ld_cnt_q;
    if (in_issue) begin
      x_addr_o = k_q;
      w_addr_o = WW'(row_q) * WW'(M) + WW'(k_q);
    end
    x_addr_d = x_addr_o;
    w_addr_d = w_addr_o;
  end

  // Next-state and counter logic for LOAD -> ISSUE -> DRAIN -> OUT.
  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    k_d      = k_q;
    row_d    = row_q;
    dcnt_d   = dcnt_q;
    case (state_q)
      S_LOAD: if (wr) begin
        ld_cnt_d = (ld_cnt_q == K_LAST) ? '0 : ld_cnt_q + 1'b1;
        if (ld_cnt_q == K_LAST) begin
          row_d   = '0;
          k_d     = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        k_d = (k_q == K_LAST) ? '0 : k_q + 1'b1;
        if (k_q == K_LAST) begin
          dcnt_d  = '0;
          state_d = S_DRAIN;
        end
      end
      // Last read needs RD_LAT cycles to reach the MAC before the result is final.
      S_DRAIN: begin
        if (dcnt_q == D_LAST) state_d = S_OUT;
        else                  dcnt_d  = dcnt_q + 1'b1;
      end
      S_OUT: if (out_hs) begin
        if (row_q == R_LAST) begin
          row_d    = '0;
          ld_cnt_d = '0;
          state_d  = S_LOAD;
        end else begin
          row_d   = row_q + 1'b1;
          k_d     = '0;
          state_d = S_ISSUE;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_LOAD;
      ld_cnt_q <= '0;
      k_q      <= '0;
      row_q    <= '0;
      dcnt_q   <= '0;
      x_addr_q <= '0;
      w_addr_q <= '0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
      k_q      <= k_d;
      row_q    <= row_d;
      dcnt_q   <= dcnt_d;
      x_addr_q <= x_addr_d;
      w_addr_q <= w_addr_d;
    end
  end

  assign stb_in.vld   = in_issue;
  assign stb_in.first = in_issue & (k_q == '0);

  layer_ctrl_16_8_strobe_delay #(.DEPTH(RD_LAT)) u_stb (
    .clk   (clk),
    .reset (reset),
    .in_s  (stb_in),
    .out_s (stb_out)
  );

  assign bus.s_ready = in_load;
  assign bus.x_wr_en = wr;
  assign bus.x_addr  = x_addr_o;
  assign bus.w_addr  = w_addr_o;
  assign bus.mac_en  = stb_out.vld;
  assign bus.mac_clr = stb_out.vld & stb_out.first;
  assign bus.m_valid = (state_q == S_OUT);
  assign bus.y_row   = row_q;
  assign bus.busy    = ~in_load;

endmodule

// File: tb/tb_layer_ctrl_16_8.sv
// Scoreboard bench for layer_ctrl_16_8: RD_LAT=1 main instance plus an RD_LAT=3 instance.
module tb_layer_ctrl_16_8;
  localparam int M   = 16;
  localparam int N   = 8;
  localparam int LAT = 1;

  typedef struct { int addr; bit first; } mac_exp_t;

  logic clk, rst;
  int   n_chk, n_bad;

  layer_ctrl_16_8_if #(.M(M), .N(N)) a_if ();
  layer_ctrl_16_8_if #(.M(M), .N(N)) b_if ();

  layer_ctrl_16_8 #(.M(M), .N(N), .RD_LAT(LAT)) dut_a (.clk(clk), .reset(rst), .bus(a_if.master));
  layer_ctrl_16_8 #(.M(M), .N(N), .RD_LAT(3))   dut_b (.clk(clk), .reset(rst), .bus(b_if.master));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_if.s_valid = 1'b0; a_if.m_ready = 1'b0;
    b_if.s_valid = 1'b0; b_if.m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_chk++; if (a_if.s_ready !== 1'b1) begin n_bad++; $display("FAIL rst_s_ready got=%b exp=1", a_if.s_ready); end
    n_chk++; if (a_if.x_wr_en !== 1'b0) begin n_bad++; $display("FAIL rst_x_wr_en got=%b exp=0", a_if.x_wr_en); end
    n_chk++; if (a_if.mac_en  !== 1'b0) begin n_bad++; $display("FAIL rst_mac_en got=%b exp=0", a_if.mac_en); end
    n_chk++; if (a_if.mac_clr !== 1'b0) begin n_bad++; $display("FAIL rst_mac_clr got=%b exp=0", a_if.mac_clr); end
    n_chk++; if (a_if.m_valid !== 1'b0) begin n_bad++; $display("FAIL rst_m_valid got=%b exp=0", a_if.m_valid); end
    n_chk++; if (a_if.busy    !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%b exp=0", a_if.busy); end
    n_chk++; if (a_if.x_addr  !== 4'd0) begin n_bad++; $display("FAIL rst_x_addr got=%0d exp=0", a_if.x_addr); end
    n_chk++; if (a_if.w_addr  !== 7'd0) begin n_bad++; $display("FAIL rst_w_addr got=%0d exp=0", a_if.w_addr); end
    n_chk++; if (a_if.y_row   !== 3'd0) begin n_bad++; $display("FAIL rst_y_row got=%0d exp=0", a_if.y_row); end
    n_chk++; if (b_if.s_ready !== 1'b1) begin n_bad++; $display("FAIL rst_b_s_ready got=%b exp=1", b_if.s_ready); end
    n_chk++; if (b_if.mac_en  !== 1'b0) begin n_bad++; $display("FAIL rst_b_mac_en got=%b exp=0", b_if.mac_en); end
  endtask

  // Load a vector then run every row; optional toggled load, backpressure row, or abort row.
  task automatic run_layer(input bit toggle, input int hold_row, input int abort_row, input bit chk_total);
    int       exp_wr[$];
    mac_exp_t exp_mac[$];
    mac_exp_t e;
    logic [6:0] w_hist [0:63];
    int ld, c, total, exp_done, wa;
    bit done;
    ld = 0; c = 0; total = 0;
    while (ld < M && c < 64) begin
      tick();
      a_if.s_valid = toggle ? (c % 2 == 0) : 1'b1;
      a_if.m_ready = 1'($urandom_range(0, 1));
      if (a_if.s_valid) begin exp_wr.push_back(ld); ld++; end
      @(negedge clk);
      total++;
      n_chk++; if (a_if.s_ready !== 1'b1) begin n_bad++; $display("FAIL ld_s_ready cyc=%0d got=%b exp=1", c, a_if.s_ready); end
      n_chk++; if (a_if.x_wr_en !== a_if.s_valid) begin n_bad++; $display("FAIL ld_x_wr_en cyc=%0d got=%b exp=%b", c, a_if.x_wr_en, a_if.s_valid); end
      n_chk++; if (a_if.busy !== 1'b0) begin n_bad++; $display("FAIL ld_busy cyc=%0d got=%b exp=0", c, a_if.busy); end
      if (a_if.x_wr_en === 1'b1) begin
        n_chk++;
        if (exp_wr.size() == 0) begin n_bad++; $display("FAIL ld_extra_write addr=%0d exp=none", a_if.x_addr); end
        else begin
          wa = exp_wr.pop_front();
          if (a_if.x_addr !== wa[3:0]) begin n_bad++; $display("FAIL ld_x_addr got=%0d exp=%0d", a_if.x_addr, wa); end
        end
      end
      c++;
    end
    n_chk++; if (exp_wr.size() != 0) begin n_bad++; $display("FAIL ld_missing_writes got=%0d exp=0", exp_wr.size()); end

    for (int r = 0; r < N; r++) begin
      c = 0; done = 1'b0;
      exp_done = M + LAT + ((r == hold_row) ? 5 : 0);
      while (!done && c < 48) begin
        tick();
        a_if.s_valid = 1'($urandom_range(0, 1));
        a_if.m_ready = (r == hold_row && c >= M + LAT && c < M + LAT + 5) ? 1'b0 : 1'b1;
        if (r == abort_row && c == M) rst = 1'b1;
        @(negedge clk);
        total++;
        w_hist[c] = a_if.w_addr;
        n_chk++; if (a_if.s_ready !== 1'b0) begin n_bad++; $display("FAIL row_s_ready r=%0d c=%0d got=%b exp=0", r, c, a_if.s_ready); end
        n_chk++; if (a_if.x_wr_en !== 1'b0) begin n_bad++; $display("FAIL row_x_wr_en r=%0d c=%0d got=%b exp=0", r, c, a_if.x_wr_en); end
        n_chk++; if (a_if.busy !== 1'b1) begin n_bad++; $display("FAIL row_busy r=%0d c=%0d got=%b exp=1", r, c, a_if.busy); end
        if (c < M) begin
          exp_mac.push_back('{addr: r*M + c, first: (c == 0)});
          n_chk++; if (a_if.w_addr !== 7'(r*M + c)) begin n_bad++; $display("FAIL issue_w_addr r=%0d c=%0d got=%0d exp=%0d", r, c, a_if.w_addr, r*M + c); end
          n_chk++; if (a_if.x_addr !== 4'(c)) begin n_bad++; $display("FAIL issue_x_addr r=%0d c=%0d got=%0d exp=%0d", r, c, a_if.x_addr, c); end
        end
        n_chk++; if (a_if.mac_en !== (c >= LAT && c <= M - 1 + LAT)) begin n_bad++; $display("FAIL mac_en r=%0d c=%0d got=%b", r, c, a_if.mac_en); end
        if (a_if.mac_en === 1'b1) begin
          n_chk++;
          if (exp_mac.size() == 0) begin n_bad++; $display("FAIL mac_extra r=%0d c=%0d got=1 exp=0", r, c); end
          else begin
            e = exp_mac.pop_front();
            if (c < LAT || w_hist[c-LAT] !== 7'(e.addr)) begin n_bad++; $display("FAIL mac_lag_addr r=%0d c=%0d exp=%0d", r, c, e.addr); end
            n_chk++; if (a_if.mac_clr !== e.first) begin n_bad++; $display("FAIL mac_clr r=%0d c=%0d got=%b exp=%b", r, c, a_if.mac_clr, e.first); end
          end
        end else begin
          n_chk++; if (a_if.mac_clr !== 1'b0) begin n_bad++; $display("FAIL mac_clr_alone r=%0d c=%0d got=%b exp=0", r, c, a_if.mac_clr); end
        end
        n_chk++; if (a_if.m_valid !== (c >= M + LAT)) begin n_bad++; $display("FAIL m_valid r=%0d c=%0d got=%b exp=%b", r, c, a_if.m_valid, c >= M + LAT); end
        if (a_if.m_valid === 1'b1) begin
          n_chk++; if (a_if.y_row !== 3'(r)) begin n_bad++; $display("FAIL y_row c=%0d got=%0d exp=%0d", c, a_if.y_row, r); end
          if (r == hold_row) begin
            n_chk++; if (a_if.w_addr !== 7'(r*M + M - 1)) begin n_bad++; $display("FAIL hold_w_addr c=%0d got=%0d exp=%0d", c, a_if.w_addr, r*M + M - 1); end
          end
          if (a_if.m_ready === 1'b1) begin
            done = 1'b1;
            n_chk++; if (c != exp_done) begin n_bad++; $display("FAIL row_done_cycle r=%0d got=%0d exp=%0d", r, c, exp_done); end
          end
        end
        if (rst === 1'b1) begin
          tick();
          rst = 1'b0;
          a_if.s_valid = 1'b0;
          @(negedge clk);
          n_chk++; if (a_if.s_ready !== 1'b1) begin n_bad++; $display("FAIL abort_s_ready got=%b exp=1", a_if.s_ready); end
          n_chk++; if (a_if.mac_en  !== 1'b0) begin n_bad++; $display("FAIL abort_mac_en got=%b exp=0", a_if.mac_en); end
          n_chk++; if (a_if.m_valid !== 1'b0) begin n_bad++; $display("FAIL abort_m_valid got=%b exp=0", a_if.m_valid); end
          n_chk++; if (a_if.busy    !== 1'b0) begin n_bad++; $display("FAIL abort_busy got=%b exp=0", a_if.busy); end
          n_chk++; if (a_if.y_row   !== 3'd0) begin n_bad++; $display("FAIL abort_y_row got=%0d exp=0", a_if.y_row); end
          return;
        end
        c++;
      end
      if (!done) begin n_chk++; n_bad++; $display("FAIL row_timeout r=%0d got=no_handshake exp=handshake", r); end
    end
    tick();
    a_if.s_valid = 1'b0;
    @(negedge clk);
    if (chk_total) begin
      n_chk++; if (total != 16 + N*18) begin n_bad++; $display("FAIL layer_cycles got=%0d exp=%0d", total, 16 + N*18); end
    end
    n_chk++; if (a_if.s_ready !== 1'b1) begin n_bad++; $display("FAIL reenter_s_ready got=%b exp=1", a_if.s_ready); end
    n_chk++; if (a_if.busy !== 1'b0) begin n_bad++; $display("FAIL reenter_busy got=%b exp=0", a_if.busy); end
  endtask

  task automatic test_back_to_back();
    run_layer(1'b0, -1, -1, 1'b1);
  endtask

  task automatic test_toggle_backpressure();
    run_layer(1'b1, 3, -1, 1'b0);
  endtask

  task automatic test_abort_reload();
    run_layer(1'b0, -1, 5, 1'b0);
    run_layer(1'b0, -1, -1, 1'b0);
  endtask

  task automatic test_rd_lat3();
    int q[$];
    logic [6:0] wh [0:63];
    int c, e;
    bit seen;
    for (int i = 0; i < M; i++) begin
      tick();
      b_if.s_valid = 1'b1;
      b_if.m_ready = 1'b1;
      @(negedge clk);
      n_chk++; if (b_if.x_wr_en !== 1'b1 || b_if.x_addr !== 4'(i)) begin n_bad++; $display("FAIL lat3_load i=%0d got_en=%b got_addr=%0d exp_addr=%0d", i, b_if.x_wr_en, b_if.x_addr, i); end
    end
    c = 0; seen = 1'b0;
    while (!seen && c < 48) begin
      tick();
      b_if.s_valid = 1'b0;
      @(negedge clk);
      wh[c] = b_if.w_addr;
      if (c < M) q.push_back(c);
      n_chk++; if (b_if.mac_en !== (c >= 3 && c <= M + 2)) begin n_bad++; $display("FAIL lat3_mac_en c=%0d got=%b", c, b_if.mac_en); end
      if (b_if.mac_en === 1'b1) begin
        n_chk++;
        if (q.size() == 0) begin n_bad++; $display("FAIL lat3_mac_extra c=%0d got=1 exp=0", c); end
        else begin
          e = q.pop_front();
          if (c < 3 || wh[c-3] !== 7'(e)) begin n_bad++; $display("FAIL lat3_lag c=%0d exp_addr=%0d", c, e); end
          n_chk++; if (b_if.mac_clr !== (e == 0)) begin n_bad++; $display("FAIL lat3_mac_clr c=%0d got=%b exp=%b", c, b_if.mac_clr, e == 0); end
        end
      end
      if (b_if.m_valid === 1'b1) begin
        seen = 1'b1;
        n_chk++; if (c != M + 3) begin n_bad++; $display("FAIL lat3_m_valid_cycle got=%0d exp=%0d", c, M + 3); end
        n_chk++; if (b_if.y_row !== 3'd0) begin n_bad++; $display("FAIL lat3_y_row got=%0d exp=0", b_if.y_row); end
      end
      c++;
    end
    if (!seen) begin n_chk++; n_bad++; $display("FAIL lat3_timeout got=no_m_valid exp=m_valid"); end
  endtask

  initial begin
    n_chk = 0; n_bad = 0;
    rst = 1'b0;
    test_reset();
    test_back_to_back();
    test_toggle_backpressure();
    test_abort_reload();
    test_rd_lat3();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/layer_ctrl_16_8.md
# layer_ctrl_16_8

Sequencing controller for the fixed-point fully-connected layer datapath (M=16 inputs, N=8 outputs) in the SPU-Lite design.
- Accepts an input vector word-by-word into the external x-memory.
- For each output row, walks the x-memory and weight-ROM address spaces and drives MAC clear/enable.
- Presents each finished accumulator through a valid/ready output handshake.
- Contains no arithmetic datapath: it owns only addresses, strobes and handshakes.

## Interface
Parameters:
- M, 16, input-vector length (words per row)
- N, 8, number of output rows
- RD_LAT, 1, read latency of x-memory and weight ROM in cycles (≥1)

Ports:
- clk  in  1  single system clock; all state updates on posedge
- reset  in  1  synchronous, active-high reset
- s_valid  in  1  input word present on external data bus
- s_ready  out  1  controller accepts input word this cycle
- x_wr_en  out  1  x-memory write strobe (= s_valid & s_ready)
- x_addr  out  $clog2(M)  x-memory address (write during load, read during compute)
- w_addr  out  $clog2(M*N)  weight-ROM read address
- mac_clr  out  1  MAC loads product instead of accumulating
- mac_en  out  1  MAC updates accumulator this cycle
- m_valid  out  1  accumulator holds a finished row result
- m_ready  in  1  downstream accepts result
- y_row  out  $clog2(N)  row index of result on accumulator
- busy  out  1  high in any state other than LOAD

## Operation
- FSM states: LOAD, ISSUE, DRAIN, OUT.
- LOAD:
  - s_ready=1.
  - Each accepted word writes x_addr=ld_cnt, then ld_cnt++.
  - After word M-1 is accepted: row=0, k=0, go to ISSUE.
- ISSUE (M cycles):
  - Drive x_addr=k and w_addr=row*M+k; k++.
  - After k=M-1, go to DRAIN.
- DRAIN:
  - Wait until the last issued read reaches the MAC (RD_LAT cycles), then go to OUT.
- Strobe pipeline:
  - A valid bit and a first bit are shifted RD_LAT stages behind the issue cycle.
  - mac_en equals the delayed valid bit; mac_clr equals mac_en & delayed first (first = k==0).
  - mac_clr is never asserted without mac_en.
- OUT:
  - m_valid=1 and y_row=row, both held stable until m_ready.
  - On handshake: if row==N-1, go to LOAD (ld_cnt=0); else row++, k=0, go to ISSUE.
- Address outputs outside their active state hold their last value (don't-care for the bench).
- s_ready=0 in ISSUE, DRAIN and OUT; s_valid there is ignored and writes nothing.
- w_addr arithmetic is unsigned, width $clog2(M*N); maximum is M*N-1=127, so there is no wrap.
- Counter wrap: ld_cnt wraps M-1→0, k wraps M-1→0, row wraps N-1→0.

## Timing
- Reset values:
  - State: LOAD; ld_cnt, k, row: 0.
  - s_ready=1 in the first cycle after reset deasserts.
  - x_wr_en=0, mac_en=0, mac_clr=0, m_valid=0, busy=0, x_addr=0, w_addr=0, y_row=0; strobe pipeline cleared.
- Reset mid-operation:
  - Aborts at the next edge; all of the above values apply.
  - In-flight mac_en strobes are discarded.
  - The vector must be reloaded.
- Row latency (cycle 0 = first ISSUE cycle):
  - mac_en (with mac_clr) in cycle RD_LAT.
  - Last mac_en in cycle M-1+RD_LAT.
  - m_valid in cycle M+RD_LAT. For M=16, RD_LAT=1: cycle 17.
- Row period with m_ready held high: M+RD_LAT+1 = 18 cycles. The next row's ISSUE starts the cycle after the handshake.
- Full layer with m_ready=1 and s_valid=1 throughout: 16 load + 8×18 = 160 cycles; LOAD is re-entered at cycle 160.
- m_ready is sampled only while m_valid=1; early m_ready has no effect.
- Backpressure: ISSUE for the next row never begins before the current result is accepted. The accumulator is single-buffered.

## Structure
- defines_pkg holds:
  - enum typedef layer_state_t {LOAD, ISSUE, DRAIN, OUT};
  - localparams for the default M, N, RD_LAT.
- Natural sub-module: strobe_delay. It is a parameterized RD_LAT-deep shift register of {valid, first} bits with synchronous reset.
- Single clock domain throughout.

## Test plan
- Reset then 16 back-to-back s_valid words:
  - x_wr_en for x_addr 0..15 on cycles 0..15; s_ready drops after word 15.
  - w_addr 0..15 for row 0 starting the next cycle.
- m_ready tied high, M=16, N=8, RD_LAT=1:
  - m_valid rises 17 cycles after each row's first issue, with y_row=0..7.
  - w_addr runs 0..127 contiguously per row.
  - mac_clr is exactly one pulse per row, coincident with the first mac_en.
- Hold m_ready=0 for 5 cycles on row 3:
  - m_valid and y_row=3 stay stable; no mac_en, no w_addr advance.
  - Row 4 issue starts the cycle after m_ready=1.
- Toggle s_valid 1,0,1,0 during LOAD:
  - Only 16 valid words are written, at addresses 0..15 with no gaps.
  - s_valid pulses during ISSUE/OUT produce x_wr_en=0.
- Assert reset during row 5 DRAIN:
  - Next cycle: LOAD, s_ready=1, mac_en=0, m_valid=0.
  - Reload gives rows 0..7 again.
- RD_LAT=3 build:
  - mac_en lags each issue address by exactly 3 cycles.
  - m_valid comes 19 cycles after first issue.
